// File: rtl/ps2out_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// common command bytes and the microsecond-to-cycle conversion.
`timescale 1ns/1ps
package ps2out_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    function automatic int us_to_cycles(input int us, input int hz);
        return int'((longint'(us) * longint'(hz)) / longint'(1000000));
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detect on the synchronized clock. Flops reset to 1, the idle line level.
`timescale 1ns/1ps
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_s,
    output logic o_data_s,
    output logic o_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign o_clk_s  = r_clk_sync[1];
    assign o_data_s = r_data_sync[1];
    assign o_fall   = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2out.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// 8 data bits + odd parity + stop on device edges, then check the device ack.
`timescale 1ns/1ps
module ps2out
    import ps2out_pkg::*;
#(
    parameter int CLK_HZ           = 25000000,
    parameter int INHIBIT_US       = 120,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int N_INH   = us_to_cycles(INHIBIT_US, CLK_HZ);
    localparam int N_START = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
    localparam int N_FRAME = us_to_cycles(FRAME_TIMEOUT_US, CLK_HZ);
    localparam int N_TMO   = (N_START > N_FRAME) ? N_START : N_FRAME;
    localparam int N_MAX   = (N_TMO > N_INH) ? N_TMO : N_INH;
    localparam int TW      = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    localparam logic [TW-1:0] L_INH_LAST   = TW'(N_INH - 1);
    localparam logic [TW-1:0] L_START_LAST = TW'(N_START - 1);
    localparam logic [TW-1:0] L_FRAME_LAST = TW'(N_FRAME - 1);

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;

    ps2_line_sync u_sync (
        .i_clk     (clk),
        .i_res     (res),
        .i_ps2_clk (ps2_clk_in),
        .i_ps2_data(ps2_data_in),
        .o_clk_s   (w_clk_s),
        .o_data_s  (w_data_s),
        .o_fall    (w_fall)
    );

    state_t        r_state,   w_state;
    logic [TW-1:0] r_tmr,     w_tmr;
    logic [3:0]    r_bits,    w_bits;
    logic [9:0]    r_shift,   w_shift;
    logic          r_data_oe, w_data_oe;
    logic          r_done,    w_done;
    logic          r_error,   w_error;
    logic          w_expired;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_tmr     <= w_tmr;
            r_bits    <= w_bits;
            r_shift   <= w_shift;
            r_data_oe <= w_data_oe;
            r_done    <= w_done;
            r_error   <= w_error;
        end
    end

    // Until the first device edge the long start timeout applies, afterwards the frame timeout.
    assign w_expired = (r_state == DATA && r_bits == 4'd0) ? (r_tmr == L_START_LAST)
                                                           : (r_tmr == L_FRAME_LAST);

    always_comb begin
        w_state   = r_state;
        w_tmr     = r_tmr;
        w_bits    = r_bits;
        w_shift   = r_shift;
        w_data_oe = r_data_oe;
        w_done    = 1'b0;
        w_error   = 1'b0;
        case (r_state)
            IDLE: begin
                w_data_oe = 1'b0;
                if (send) begin
                    w_shift = {1'b1, ~^data, data};
                    w_tmr   = '0;
                    w_state = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_tmr == L_INH_LAST) begin
                    w_data_oe = 1'b1;
                    w_state   = RTS;
                end else begin
                    w_tmr = r_tmr + TW'(1);
                end
            end
            RTS: begin
                w_tmr   = '0;
                w_bits  = '0;
                w_state = DATA;
            end
            DATA: begin
                if (w_expired) begin
                    w_data_oe = 1'b0;
                    w_error   = 1'b1;
                    w_state   = IDLE;
                end else if (w_fall) begin
                    w_data_oe = ~r_shift[0];
                    w_shift   = {1'b0, r_shift[9:1]};
                    w_bits    = r_bits + 4'd1;
                    w_tmr     = (r_bits == 4'd0) ? '0 : r_tmr + TW'(1);
                    if (r_bits == 4'd9) begin
                        w_state = ACK;
                    end
                end else begin
                    w_tmr = r_tmr + TW'(1);
                end
            end
            ACK: begin
                if (w_expired) begin
                    w_data_oe = 1'b0;
                    w_error   = 1'b1;
                    w_state   = IDLE;
                end else if (w_fall) begin
                    if (w_data_s) begin
                        w_error = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_state = WAIT_IDLE;
                    end
                end else begin
                    w_tmr = r_tmr + TW'(1);
                end
            end
            WAIT_IDLE: begin
                if (w_clk_s && w_data_s) begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
            end
            default: begin
                w_data_oe = 1'b0;
                w_state   = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = (r_state == INHIBIT) || (r_state == RTS);
    assign ps2_data_oe = r_data_oe;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2out.sv
// Directed and randomized bench for ps2out with an open-collector PS/2 device
// model that clocks bits in, checks odd parity and returns the ack.
`timescale 1ns/1ps
module tb_ps2out;
    import ps2out_pkg::*;

    localparam int CLK_HZ = 1000000;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       line_clk, line_data;

    assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign line_data = ~(ps2_data_oe | dev_data_low);

    ps2out #(
        .CLK_HZ          (CLK_HZ),
        .INHIBIT_US      (120),
        .START_TIMEOUT_US(15000),
        .FRAME_TIMEOUT_US(2000)
    ) dut (
        .clk        (clk),
        .res        (res),
        .ps2_clk_in (line_clk),
        .ps2_data_in(line_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .send       (send),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #500 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic do_send(input logic [7:0] b);
        @(negedge clk);
        data = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Device side: measure inhibit, then generate n_edges clock pulses, sampling
    // the data line at the end of each low phase and pulling ack when asked.
    task automatic dev_xfer(input int n_edges, input bit ack_low, input int half, input bit dup,
                            output logic [9:0] rx, output int low_cycles,
                            output int rel_cyc, output int first_edge_cyc);
        int w;
        rx = '0;
        low_cycles = 0;
        first_edge_cyc = 0;
        w = 0;
        while (!ps2_clk_oe && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("inhibit_seen", ps2_clk_oe, 1'b1);
        while (ps2_clk_oe && low_cycles < 1000) begin
            if (dup && low_cycles == 5) begin
                data = 8'h00;
                send = 1'b1;
            end
            if (dup && low_cycles == 6) send = 1'b0;
            @(negedge clk);
            low_cycles++;
        end
        rel_cyc = cyc;
        chk("start_bit", line_data, 1'b0);
        if (n_edges > 0) repeat (10) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1) first_edge_cyc = cyc;
            repeat (half) @(negedge clk);
            if (k <= 10) rx[k-1] = line_data;
            dev_clk_low = 1'b0;
            if (k == 10 && ack_low) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
            if (k == 11) dev_data_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic full_xfer(input logic [7:0] b, input bit dup, input int half);
        logic [9:0] rx;
        int low, rel, fe, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(b);
        dev_xfer(11, 1'b1, half, dup, rx, low, rel, fe);
        repeat (10) @(negedge clk);
        chk("byte", rx[7:0], b);
        chk("parity", rx[8], ($countones(b) % 2 == 0) ? 1 : 0);
        chk("odd_total", $countones(rx[8:0]) % 2, 1);
        chk("stop", rx[9], 1'b1);
        chk_rng("inhibit_len", low, 120, 125);
        chk("done_pulses", done_cnt - d0, 1);
        chk("err_pulses", err_cnt - e0, 0);
        chk("busy_after", busy, 1'b0);
        chk("oe_after", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    endtask

    initial begin
        logic [9:0] rx;
        int low, rel, fe, d0, e0, w;

        repeat (2) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_data_oe", ps2_data_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        res = 1'b1;
        repeat (3) @(negedge clk);

        full_xfer(CMD_SET_LEDS, 1'b1, 40);
        full_xfer(8'h07, 1'b0, 40);
        full_xfer(CMD_RESET, 1'b0, 40);
        for (int i = 0; i < 4; i++) begin
            full_xfer(8'($urandom), 1'b0, int'($urandom_range(45, 30)));
        end

        // device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(CMD_RESET);
        dev_xfer(0, 1'b1, 40, 1'b0, rx, low, rel, fe);
        w = 0;
        while (!error && w < 16000) begin
            @(negedge clk);
            w++;
        end
        chk("start_tmo_err", error, 1'b1);
        chk_rng("start_tmo_time", cyc - rel, 14999, 15001);
        chk("start_tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("start_tmo_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("start_tmo_pulses", err_cnt - e0, 1);
        chk("start_tmo_nodone", done_cnt - d0, 0);

        // device stops after 5 edges
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(8'($urandom));
        dev_xfer(5, 1'b1, 40, 1'b0, rx, low, rel, fe);
        w = 0;
        while (!error && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("frame_tmo_err", error, 1'b1);
        chk_rng("frame_tmo_time", cyc - fe, 1997, 2006);
        chk("frame_tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("frame_tmo_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("frame_tmo_pulses", err_cnt - e0, 1);
        chk("frame_tmo_nodone", done_cnt - d0, 0);

        // device leaves ack high
        d0 = done_cnt;
        e0 = err_cnt;
        do_send(CMD_ENABLE);
        dev_xfer(11, 1'b0, 40, 1'b0, rx, low, rel, fe);
        repeat (10) @(negedge clk);
        chk("nack_byte", rx[7:0], CMD_ENABLE);
        chk("nack_err", err_cnt - e0, 1);
        chk("nack_nodone", done_cnt - d0, 0);
        chk("nack_busy", busy, 1'b0);

        // reset in the middle of a frame
        do_send(8'h00);
        dev_xfer(4, 1'b1, 40, 1'b0, rx, low, rel, fe);
        chk("pre_rst_data_oe", ps2_data_oe, 1'b1);
        chk("pre_rst_busy", busy, 1'b1);
        res = 1'b0;
        #1;
        chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        res = 1'b1;
        repeat (3) @(negedge clk);
        full_xfer(CMD_ENABLE, 1'b0, 40);

        chk("done_error_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2out.md
PS2OUT -- requirements
Module: ps2out

Interface
REQ-001 Parameter CLK_HZ, default 25000000, frequency of clk in Hz; SHALL be at least 1000000.
REQ-002 Parameter INHIBIT_US, default 120, time ps2_clk is held low before request-to-send.
REQ-003 Parameter START_TIMEOUT_US, default 15000, maximum wait from clock release to the first device falling edge.
REQ-004 Parameter FRAME_TIMEOUT_US, default 2000, maximum time from the first device falling edge to the ack sample.
REQ-005 clk  in  1  module clock; all logic is on its rising edge.
REQ-006 res  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-007 ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous).
REQ-008 ps2_data_in  in  1  raw PS/2 data line level (asynchronous).
REQ-009 ps2_clk_oe  out  1  1 = pull PS/2 clock low (open collector); 0 = release.
REQ-010 ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
REQ-011 send  in  1  request to transmit data; sampled only in IDLE.
REQ-012 data  in  8  command byte to transmit (e.g. 8'hED LED set, 8'hFF reset).
REQ-013 busy  out  1  high from the accepted send until done or error.
REQ-014 done  out  1  one-cycle pulse: byte sent and acknowledged.
REQ-015 error  out  1  one-cycle pulse: timeout, or ack bit sampled high.

Function
REQ-016 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a device falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-017 IDLE: busy=0 and both oe=0; send=1 latches data, forms shift = {1'b1 stop, ~^data odd parity, data[7:0]}, sets busy=1, and moves to INHIBIT on the next edge.
REQ-018 INHIBIT: ps2_clk_oe=1 for INHIBIT_US*CLK_HZ/1e6 cycles, then RTS.
REQ-019 RTS: ps2_clk_oe=1 and ps2_data_oe=1 (start bit) for exactly one cycle, then DATA with ps2_clk_oe=0, ps2_data_oe held 1, and the bit counter cleared.
REQ-020 DATA: on each synced falling edge, ps2_data_oe <= ~shift[0], shift right, counter+1; the 10th edge (stop bit, data released) moves to ACK.
REQ-021 ACK: on the 11th falling edge, sample synced data; 0 moves to WAIT_IDLE, 1 raises error and returns to IDLE.
REQ-022 WAIT_IDLE: wait until synced clock and data are both 1, then pulse done for one cycle and enter IDLE (busy=0 in the same cycle).
REQ-023 Start timeout: if no falling edge arrives within START_TIMEOUT_US of entering DATA, release both lines, pulse error, and enter IDLE.
REQ-024 Frame timeout: if ACK has not completed within FRAME_TIMEOUT_US of the first falling edge, release both lines, pulse error, and enter IDLE.
REQ-025 send while busy SHALL be ignored, not queued; data is sampled only at acceptance.
REQ-026 done and error SHALL never assert in the same cycle; at most one of them fires per accepted send.
REQ-027 Counter widths SHALL be $clog2 of the largest cycle count, with no wrap before the timeout fires.
REQ-028 Data SHALL be sent LSB first; the parity bit SHALL make the total number of ones across the 9 bits odd.

Reset
REQ-029 res=0 SHALL force IDLE asynchronously: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, counters, shift register and synchronizers cleared (synchronizers to 1, the idle line level).
REQ-030 Reset mid-frame SHALL release both lines immediately; after release, the first send starts a fresh INHIBIT.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE) and the PS/2 command constants (8'hED, 8'hFF, 8'hF4).
REQ-032 One sub-module, ps2_line_sync, SHALL implement the two synchronizers and the falling-edge detect; the FSM, counters and shift register stay in ps2out.

Verification
REQ-033 Device model at 12.5 kHz; send data=8'hED -> clock held low ≥120 us, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, model acks 0 -> single done pulse, busy low.
REQ-034 data=8'h07 -> parity bit 0; data=8'hFF -> parity bit 1; the model checks the odd-parity total.
REQ-035 Device never clocks -> error pulse at 15 ms ±1 cycle after clock release, both oe=0, busy=0.
REQ-036 Model stops after 5 edges -> error at 2 ms from the first edge; model leaves ack high -> error on the 11th edge, no done.
REQ-037 res=0 asserted at bit 4 -> both oe=0 in the same cycle; a following send of 8'hF4 completes with done.
REQ-038 send pulsed again while busy with data=8'h00 -> ignored; transmitted byte stays 8'hED.
